// File: rtl/ptw_walker_pkg.sv
// Shared definitions for the Sv32 page-table walker.
// Contents: walker FSM state encodings, PTE bit indices and fault codes.
// The state names carry a PTW_ prefix so they cannot collide with the
// TLB controller's own state enum when both packages are imported.
package ptw_walker_pkg;

    // Sv32 PTE flag bit positions
    localparam int PTE_V = 0;
    localparam int PTE_R = 1;
    localparam int PTE_W = 2;
    localparam int PTE_X = 3;
    localparam int PTE_U = 4;
    localparam int PTE_G = 5;
    localparam int PTE_A = 6;
    localparam int PTE_D = 7;

    // Fault codes returned on ptw_resp_fault_o
    localparam logic [1:0] FAULT_NONE     = 2'd0;
    localparam logic [1:0] FAULT_INVALID  = 2'd1;
    localparam logic [1:0] FAULT_MISALIGN = 2'd2;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'd3;

    typedef enum logic [2:0] {
        PTW_IDLE    = 3'd0,
        PTW_L1_REQ  = 3'd1,
        PTW_L1_WAIT = 3'd2,
        PTW_L0_REQ  = 3'd3,
        PTW_L0_WAIT = 3'd4,
        PTW_RESP    = 3'd5
    } ptw_state_e;

endpackage

// File: rtl/ptw_walker_pte_decode.sv
// Combinational Sv32 PTE classifier.
// Ports:
//   pte_i           PTE word returned by memory
//   level_i         1 = PTE came from the root (level-1) table
//   vpn0_i          low VPN field, merged into a superpage PPN
//   is_invalid_o    V=0, or the reserved R=0/W=1 encoding
//   is_leaf_o       R or X set
//   is_misaligned_o level-1 leaf whose PPN[0] field is nonzero
//   ppn_o           leaf PPN (superpage form when level_i=1)
module ptw_pte_decode
    import ptw_walker_pkg::*;
(
    input  logic [31:0] pte_i,
    input  logic        level_i,
    input  logic [9:0]  vpn0_i,
    output logic        is_invalid_o,
    output logic        is_leaf_o,
    output logic        is_misaligned_o,
    output logic [21:0] ppn_o
);

    // RSW bits carry no meaning for translation
    logic unused_rsw;
    assign unused_rsw = ^pte_i[9:8];

    assign is_invalid_o    = !pte_i[PTE_V] || (!pte_i[PTE_R] && pte_i[PTE_W]);
    assign is_leaf_o       = pte_i[PTE_R] || pte_i[PTE_X];
    assign is_misaligned_o = level_i && is_leaf_o && (pte_i[19:10] != 10'd0);
    // A 4 MiB superpage takes its low PPN field from the virtual address
    assign ppn_o           = level_i ? {pte_i[31:20], vpn0_i} : pte_i[31:10];

endmodule

// File: rtl/ptw_walker.sv
// Sv32 two-level page-table walker, responder side of the TLB PTW port.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   satp_ppn_i                     root table PPN, sampled at request accept
//   ptw_req_valid_i/ready_o/vpn_i  walk request from the TLB
//   ptw_resp_*                     walk result (ppn, perm, level, fault)
//   mem_req_valid_o/ready_i/addr_o single-outstanding PTE read request
//   mem_resp_valid_i/data_i        PTE read data (always consumed in WAIT)
// Every output is a register or a decode of the state register.
module ptw_walker
    import ptw_walker_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int TMR_W          = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [21:0] satp_ppn_i,
    input  logic        ptw_req_valid_i,
    output logic        ptw_req_ready_o,
    input  logic [19:0] ptw_req_vpn_i,
    output logic        ptw_resp_valid_o,
    input  logic        ptw_resp_ready_i,
    output logic [21:0] ptw_resp_ppn_o,
    output logic [7:0]  ptw_resp_perm_o,
    output logic        ptw_resp_level_o,
    output logic [1:0]  ptw_resp_fault_o,
    output logic        mem_req_valid_o,
    input  logic        mem_req_ready_i,
    output logic [33:0] mem_req_addr_o,
    input  logic        mem_resp_valid_i,
    input  logic [31:0] mem_resp_data_i
);

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    ptw_state_e        state_q, state_d;
    logic [9:0]        vpn0_q, vpn0_d;
    logic [33:0]       addr_q, addr_d;
    logic [21:0]       ppn_q, ppn_d;
    logic [7:0]        perm_q, perm_d;
    logic              level_q, level_d;
    logic [1:0]        fault_q, fault_d;
    logic [TMR_W-1:0]  timer_q, timer_d;

    logic              dec_invalid, dec_leaf, dec_misaligned;
    logic [21:0]       dec_ppn;

    ptw_pte_decode u_decode (
        .pte_i           (mem_resp_data_i),
        .level_i         (state_q == PTW_L1_WAIT),
        .vpn0_i          (vpn0_q),
        .is_invalid_o    (dec_invalid),
        .is_leaf_o       (dec_leaf),
        .is_misaligned_o (dec_misaligned),
        .ppn_o           (dec_ppn)
    );

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PTW_IDLE;
            vpn0_q  <= '0;
            addr_q  <= '0;
            ppn_q   <= '0;
            perm_q  <= '0;
            level_q <= 1'b0;
            fault_q <= FAULT_NONE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            vpn0_q  <= vpn0_d;
            addr_q  <= addr_d;
            ppn_q   <= ppn_d;
            perm_q  <= perm_d;
            level_q <= level_d;
            fault_q <= fault_d;
            timer_q <= timer_d;
        end
    end

    // Next state and datapath
    always_comb begin
        state_d = state_q;
        vpn0_d  = vpn0_q;
        addr_d  = addr_q;
        ppn_d   = ppn_q;
        perm_d  = perm_q;
        level_d = level_q;
        fault_d = fault_q;
        timer_d = timer_q;
        case (state_q)
            PTW_IDLE: begin
                if (ptw_req_valid_i) begin
                    // satp only shapes the root address, so it need not be kept
                    vpn0_d  = ptw_req_vpn_i[9:0];
                    addr_d  = {satp_ppn_i, ptw_req_vpn_i[19:10], 2'b00};
                    state_d = PTW_L1_REQ;
                end
            end
            PTW_L1_REQ, PTW_L0_REQ: begin
                if (mem_req_ready_i) begin
                    timer_d = '0;
                    state_d = (state_q == PTW_L1_REQ) ? PTW_L1_WAIT : PTW_L0_WAIT;
                end
            end
            PTW_L1_WAIT, PTW_L0_WAIT: begin
                // A response arriving on the limit cycle still takes priority
                if (mem_resp_valid_i) begin
                    perm_d  = mem_resp_data_i[7:0];
                    ppn_d   = '0;
                    level_d = 1'b0;
                    state_d = PTW_RESP;
                    if (dec_invalid) begin
                        fault_d = FAULT_INVALID;
                    end else if (dec_leaf) begin
                        if (dec_misaligned) begin
                            fault_d = FAULT_MISALIGN;
                        end else begin
                            fault_d = FAULT_NONE;
                            ppn_d   = dec_ppn;
                            level_d = (state_q == PTW_L1_WAIT);
                        end
                    end else if (state_q == PTW_L1_WAIT) begin
                        addr_d  = {mem_resp_data_i[31:10], vpn0_q, 2'b00};
                        state_d = PTW_L0_REQ;
                    end else begin
                        // Pointer at the last level
                        fault_d = FAULT_INVALID;
                    end
                end else if (timer_q == TMR_LAST) begin
                    fault_d = FAULT_TIMEOUT;
                    ppn_d   = '0;
                    perm_d  = '0;
                    level_d = 1'b0;
                    state_d = PTW_RESP;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            PTW_RESP: begin
                if (ptw_resp_ready_i) begin
                    state_d = PTW_IDLE;
                end
            end
            default: state_d = PTW_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        ptw_req_ready_o  = (state_q == PTW_IDLE);
        mem_req_valid_o  = (state_q == PTW_L1_REQ) || (state_q == PTW_L0_REQ);
        ptw_resp_valid_o = (state_q == PTW_RESP);
        mem_req_addr_o   = addr_q;
        ptw_resp_ppn_o   = ppn_q;
        ptw_resp_perm_o  = perm_q;
        ptw_resp_level_o = level_q;
        ptw_resp_fault_o = fault_q;
    end

endmodule
